// File: rtl/adder_arb_pkg.sv
// Shared types and constants for the adder_arbiter block: FSM state
// encoding, operation codes and the requester-count upper bound.
package adder_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_RESP    = 2'd3
    } state_e;

    localparam logic OP_INC = 1'b0;
    localparam logic OP_CLR = 1'b1;

    localparam int NREQ_MAX = 16;

endpackage : adder_arb_pkg

// File: rtl/adder_arb_pick.sv
// Combinational winner selection for adder_arbiter. With ADDER_ARB_RR_EN the
// search starts at ptr and wraps; otherwise the lowest index always wins.
module adder_arb_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_valid,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id,
    output logic            any_req
);

    int base;

`ifdef ADDER_ARB_RR_EN
    assign base = int'(ptr);
`else
    logic ptr_unused;
    assign base       = 0;
    assign ptr_unused = ^ptr;
`endif

    assign any_req = |req_valid;

    // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
    always_comb begin
        logic found;
        int   idx;
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (base + i) % NREQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_id   = IDW'(idx);
            end
        end
    end

endmodule : adder_arb_pick

// File: rtl/adder_arbiter.sv
// Shares one external Adder counter between NREQ requesters; one operation in
// flight at a time. Define ADDER_ARB_RR_EN for round-robin, else fixed priority.
module adder_arbiter
    import adder_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDW   = $clog2(NREQ)
) (
    input  logic             aclk,
    input  logic             arstn,
    input  logic [NREQ-1:0]  req_valid,
    input  logic [NREQ-1:0]  req_clr,
    output logic [NREQ-1:0]  req_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [IDW-1:0]   rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             cnt_inc,
    output logic             cnt_clr,
    input  logic [WIDTH-1:0] cnt_out
);

    if (NREQ < 2 || NREQ > NREQ_MAX) begin : g_bad_nreq
        $error("adder_arbiter: NREQ must be in 2..16");
    end

    state_e           state_q, state_d;
    logic [IDW-1:0]   id_q, id_d;
    logic             op_q, op_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;

    logic [IDW-1:0]   ptr;
    logic [NREQ-1:0]  pick_grant;
    logic [IDW-1:0]   pick_id;
    logic             pick_any;

    adder_arb_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_valid (req_valid),
        .ptr       (ptr),
        .grant     (pick_grant),
        .grant_id  (pick_id),
        .any_req   (pick_any)
    );

`ifdef ADDER_ARB_RR_EN
    logic [IDW-1:0] ptr_q, ptr_d;

    // Pointer advances past the served requester only once its response is taken.
    always_comb begin
        ptr_d = ptr_q;
        if (state_q == S_RESP && rsp_ready) begin
            ptr_d = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        op_d       = op_q;
        rsp_id_d   = rsp_id_q;
        rsp_data_d = rsp_data_q;
        req_ready  = '0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // Grant is masked while reset is held so no requester sees a handshake.
                req_ready = arstn ? pick_grant : '0;
                if (pick_any) begin
                    id_d    = pick_id;
                    op_d    = (|(req_clr & pick_grant)) ? OP_CLR : OP_INC;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_clr = (op_q == OP_CLR);
                cnt_inc = (op_q == OP_INC);
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                rsp_data_d = cnt_out;
                rsp_id_d   = id_q;
                state_d    = S_RESP;
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    // NOTE: every register here is control/datapath state, so all get an async reset value.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            state_q    <= S_IDLE;
            id_q       <= '0;
            op_q       <= OP_INC;
            rsp_id_q   <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            op_q       <= op_d;
            rsp_id_q   <= rsp_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign rsp_id   = rsp_id_q;
    assign rsp_data = rsp_data_q;

endmodule : adder_arbiter

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter with a behavioural Adder
// counter; expectations adapt to ADDER_ARB_RR_EN.
module tb_adder_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int IDW   = 2;

    logic             aclk;
    logic             arstn;
    logic [NREQ-1:0]  req_valid;
    logic [NREQ-1:0]  req_clr;
    logic [NREQ-1:0]  req_ready;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDW-1:0]   rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             cnt_inc;
    logic             cnt_clr;
    logic [WIDTH-1:0] cnt_out;

    int n_tests = 0;
    int n_fail  = 0;

    adder_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .IDW   (IDW)
    ) dut (
        .aclk      (aclk),
        .arstn     (arstn),
        .req_valid (req_valid),
        .req_clr   (req_clr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .cnt_inc   (cnt_inc),
        .cnt_clr   (cnt_clr),
        .cnt_out   (cnt_out)
    );

    // Behavioural stand-in for the external Adder counter.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn)       cnt_out <= '0;
        else if (cnt_clr) cnt_out <= '0;
        else if (cnt_inc) cnt_out <= cnt_out + 1'b1;
    end

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge aclk);
        arstn     = 1'b0;
        req_valid = '0;
        req_clr   = '0;
        rsp_ready = 1'b1;
        repeat (2) @(negedge aclk);
        arstn = 1'b1;
    endtask

    // Waits for rsp_valid at negedges; cycles = negedges waited.
    task automatic wait_rsp(output int cycles);
        bit seen;
        seen   = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge aclk);
            if (rsp_valid) begin
                seen   = 1'b1;
                cycles = i;
                break;
            end
        end
        if (!seen) check("rsp_timeout", 32'd0, 32'd1);
    endtask

    // Single isolated operation with rsp_ready high, checked cycle by cycle.
    task automatic do_op(input int id, input logic clr, input logic [WIDTH-1:0] exp);
        logic [NREQ-1:0] onehot;
        onehot = NREQ'(1 << id);
        @(negedge aclk);
        req_valid = onehot;
        req_clr   = clr ? onehot : '0;
        #1;
        check("grant_ready", 32'(req_ready), 32'(onehot));
        @(negedge aclk);
        req_valid = '0;
        req_clr   = '0;
        check("issue_inc", 32'(cnt_inc), 32'(!clr));
        check("issue_clr", 32'(cnt_clr), 32'(clr));
        check("issue_ready", 32'(req_ready), 32'd0);
        @(negedge aclk);
        check("capture_pulse", 32'({cnt_inc, cnt_clr}), 32'd0);
        check("capture_valid", 32'(rsp_valid), 32'd0);
        @(negedge aclk);
        check("resp_valid", 32'(rsp_valid), 32'd1);
        check("resp_id", 32'(rsp_id), 32'(id));
        check("resp_data", 32'(rsp_data), 32'(exp));
    endtask

    initial begin
        int cyc;
        int exp_id;
        bit stray;
        logic [WIDTH-1:0] held_data;

        arstn     = 1'b0;
        req_valid = '0;
        req_clr   = '0;
        rsp_ready = 1'b1;

        // Reset state, including a request pending while reset is held.
        repeat (2) @(negedge aclk);
        req_valid = 4'b1111;
        #1;
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_data", 32'(rsp_data), 32'd0);
        check("rst_cnt", 32'({cnt_inc, cnt_clr}), 32'd0);
        req_valid = '0;
        @(negedge aclk);
        arstn = 1'b1;

        // Single increment from requester 2.
        do_op(2, 1'b0, 8'd1);

        // All requesters incrementing continuously.
        do_reset();
        @(negedge aclk);
        req_valid = 4'b1111;
        #1;
        check("rr_first_ready", 32'(req_ready), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            wait_rsp(cyc);
            check("rr_interval", 32'(cyc), (k == 0) ? 32'd3 : 32'd4);
`ifdef ADDER_ARB_RR_EN
            exp_id = k % NREQ;
`else
            exp_id = 0;
`endif
            check("rr_id", 32'(rsp_id), 32'(exp_id));
            check("rr_data", 32'(rsp_data), 32'(k + 1));
        end
        req_valid = '0;

        // Clear from requester 1 after five increments, then one increment.
        do_op(1, 1'b1, 8'd0);
        do_op(0, 1'b0, 8'd1);

        // Wrap-around over 256 increments.
        do_reset();
        for (int k = 1; k <= 256; k++) begin
            do_op(3, 1'b0, WIDTH'(k));
        end

        // Hold the response for 10 cycles with another request waiting.
        @(negedge aclk);
        rsp_ready = 1'b0;
        req_valid = 4'b0100;
        wait_rsp(cyc);
        check("stall_latency", 32'(cyc), 32'd3);
        check("stall_id0", 32'(rsp_id), 32'd2);
        check("stall_data0", 32'(rsp_data), 32'd1);
        held_data = 8'd1;
        req_valid = 4'b0001;
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_id", 32'(rsp_id), 32'd2);
            check("stall_data", 32'(rsp_data), 32'(held_data));
            check("stall_ready", 32'(req_ready), 32'd0);
            check("stall_inc", 32'(cnt_inc), 32'd0);
        end
        rsp_ready = 1'b1;
        wait_rsp(cyc);
        req_valid = '0;
        check("after_stall_gap", 32'(cyc), 32'd4);
        check("after_stall_id", 32'(rsp_id), 32'd0);
        check("after_stall_data", 32'(rsp_data), 32'd2);

        // Reset asserted during ISSUE.
        @(negedge aclk);
        req_valid = 4'b1000;
        #1;
        check("mid_grant", 32'(req_ready), 32'b1000);
        @(negedge aclk);
        req_valid = '0;
        check("mid_issue_inc", 32'(cnt_inc), 32'd1);
        #2;
        arstn = 1'b0;
        #1;
        check("mid_rst_ready", 32'(req_ready), 32'd0);
        check("mid_rst_cnt", 32'({cnt_inc, cnt_clr}), 32'd0);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_id", 32'(rsp_id), 32'd0);
        check("mid_rst_data", 32'(rsp_data), 32'd0);
        @(negedge aclk);
        arstn = 1'b1;
        stray = 1'b0;
        repeat (5) begin
            @(negedge aclk);
            if (rsp_valid) stray = 1'b1;
        end
        check("mid_no_resp", 32'(stray), 32'd0);
        req_valid = 4'b1111;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'b0001);
        wait_rsp(cyc);
        req_valid = '0;
        check("post_rst_id", 32'(rsp_id), 32'd0);
        check("post_rst_data", 32'(rsp_data), 32'd1);

        @(negedge aclk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_adder_arbiter
